// File: rtl/arrow_board_seq.sv
`default_nettype none
// ============================================================================
// Module   : arrow_board_seq
// Brief    : Self-timed arrow-board controller with prescaler, step sequencer,
//            frame-aligned mode register and registered lamp composition.
//            Optional PWM dimming is enabled by defining ARROWBOARD_DIM_EN.
// Revision : 1.0
// ============================================================================
module arrow_board_seq #(
  parameter int N_LAMPS   = 16,
  parameter int SEQ_STEPS = 4,
  parameter int DIV       = 2,
  parameter int DIV_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic [2:0]                         mode_req,
  input  logic                               mode_load,
  input  logic                               lt,
  input  logic                               bi,
  input  logic                               al,
`ifdef ARROWBOARD_DIM_EN
  input  logic [3:0]                         dim,
`endif
  output logic [N_LAMPS-1:0]                 lamps,
  output logic [$clog2(SEQ_STEPS+2)-1:0]     step,
  output logic                               frame_start,
  output logic                               mode_pending
);

  localparam int c_STEP_W = $clog2(SEQ_STEPS + 2);
  localparam int c_SEG    = N_LAMPS / SEQ_STEPS;
  localparam int c_HALF   = N_LAMPS / 2;

  localparam logic [2:0] c_MODE_OFF     = 3'd0;
  localparam logic [2:0] c_MODE_RIGHT   = 3'd1;
  localparam logic [2:0] c_MODE_LEFT    = 3'd2;
  localparam logic [2:0] c_MODE_FLASH   = 3'd3;
  localparam logic [2:0] c_MODE_CAUTION = 3'd4;
  localparam logic [2:0] c_MODE_CHASE   = 3'd5;
  localparam logic [2:0] c_MODE_DOUBLE  = 3'd6;

  logic [DIV_W-1:0]    r_presc;
  logic [c_STEP_W-1:0] r_step;
  logic [2:0]          r_mode;
  logic [2:0]          r_pending;
  logic                r_mode_pending;
  logic                r_frame_start;
  logic [N_LAMPS-1:0]  r_lamps;

  logic                w_tick;
  logic                w_wrap;
  logic                w_apply_off;
  logic                w_hold;
  int                  w_s;
  logic [N_LAMPS-1:0]  w_fill;
  logic [c_HALF-1:0]   w_half;
  logic [N_LAMPS-1:0]  w_data;
  logic [N_LAMPS-1:0]  w_lit;
  logic [N_LAMPS-1:0]  w_lamps_nxt;

  assign w_tick      = ena && (r_presc == DIV_W'(DIV - 1));
  assign w_wrap      = (r_step == c_STEP_W'(SEQ_STEPS + 1));
  // An idle (OFF) board takes a pending mode immediately instead of waiting for a frame edge.
  assign w_apply_off = r_mode_pending && (r_mode == c_MODE_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc        <= '0;
      r_step         <= '0;
      r_mode         <= c_MODE_OFF;
      r_pending      <= c_MODE_OFF;
      r_mode_pending <= 1'b0;
      r_frame_start  <= 1'b0;
      r_lamps        <= '0;
    end else begin
      if (mode_load) r_pending <= mode_req;
      if (w_apply_off) begin
        r_mode         <= r_pending;
        r_step         <= '0;
        r_presc        <= '0;
        r_mode_pending <= mode_load;
      end else begin
        if (ena) r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_step <= w_wrap ? '0 : r_step + 1'b1;
        if (w_tick && w_wrap && r_mode_pending) begin
          r_mode         <= r_pending;
          r_mode_pending <= mode_load;
        end else if (mode_load) begin
          r_mode_pending <= 1'b1;
        end
      end
      r_frame_start <= w_tick && w_wrap && !w_apply_off;
      r_lamps       <= w_lamps_nxt;
    end
  end

  always_comb begin
    w_fill = '0;
    w_half = '0;
    w_data = '0;
    w_s    = int'(r_step);
    w_hold = (w_s >= SEQ_STEPS);
    for (int i = 0; i < N_LAMPS; i++) begin
      w_fill[i] = w_hold || (i < (w_s + 1) * c_SEG);
    end
    // Each half of DOUBLE_SEQ runs the fill sequence compressed into N_LAMPS/2 lamps.
    for (int j = 0; j < c_HALF; j++) begin
      w_half[j] = w_hold || (j < ((w_s + 1) * c_HALF) / SEQ_STEPS);
    end
    case (r_mode)
      c_MODE_OFF:   w_data = '0;
      c_MODE_RIGHT: w_data = w_fill;
      c_MODE_LEFT: begin
        for (int i = 0; i < N_LAMPS; i++) w_data[i] = w_fill[N_LAMPS-1-i];
      end
      c_MODE_FLASH: w_data = {N_LAMPS{~r_step[0]}};
      c_MODE_CAUTION: begin
        for (int i = 0; i < N_LAMPS; i++) w_data[i] = (i < c_HALF) ? ~r_step[0] : r_step[0];
      end
      c_MODE_CHASE: begin
        for (int i = 0; i < N_LAMPS; i++) w_data[i] = !w_hold && ((i / c_SEG) == w_s);
      end
      c_MODE_DOUBLE: begin
        for (int j = 0; j < c_HALF; j++) begin
          w_data[c_HALF+j]   = w_half[j];
          w_data[c_HALF-1-j] = w_half[j];
        end
      end
      default:      w_data = '1;
    endcase
  end

`ifdef ARROWBOARD_DIM_EN
  logic [3:0] r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm <= '0;
    else        r_pwm <= r_pwm + 4'd1;
  end

  assign w_lit = w_data & {N_LAMPS{r_pwm <= dim}};
`else
  assign w_lit = w_data;
`endif

  // Lamp test lights lamps after dimming so it always shows full brightness; blanking wins over it.
  assign w_lamps_nxt = ((w_lit | {N_LAMPS{~lt}}) & {N_LAMPS{bi}}) ^ {N_LAMPS{~al}};

  assign lamps        = r_lamps;
  assign step         = r_step;
  assign frame_start  = r_frame_start;
  assign mode_pending = r_mode_pending;

endmodule
`default_nettype wire

// File: tb/tb_arrow_board_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_arrow_board_seq
// Brief    : Self-checking bench for arrow_board_seq (16 lamps, 4 steps, DIV 2).
// Revision : 1.0
// ============================================================================
module tb_arrow_board_seq;

  localparam int N   = 16;
  localparam int S   = 4;
  localparam int DIV = 2;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        ena       = 1'b1;
  logic [2:0]  mode_req  = 3'd0;
  logic        mode_load = 1'b0;
  logic        lt        = 1'b1;
  logic        bi        = 1'b1;
  logic        al        = 1'b1;
`ifdef ARROWBOARD_DIM_EN
  logic [3:0]  dim       = 4'd15;
  int          m_pwm     = 0;
`endif
  logic [15:0] lamps;
  logic [2:0]  step;
  logic        frame_start;
  logic        mode_pending;

  int checks   = 0;
  int failures = 0;

  arrow_board_seq #(.N_LAMPS(N), .SEQ_STEPS(S), .DIV(DIV), .DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .mode_req     (mode_req),
    .mode_load    (mode_load),
    .lt           (lt),
    .bi           (bi),
    .al           (al),
`ifdef ARROWBOARD_DIM_EN
    .dim          (dim),
`endif
    .lamps        (lamps),
    .step         (step),
    .frame_start  (frame_start),
    .mode_pending (mode_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Lamp picture for a mode/step straight from the pattern rules, as 16-bit arithmetic.
  function automatic logic [15:0] pattern(input int mode, input int s);
    logic [15:0] fill, res;
    logic [7:0]  half, halfr;
    int n, h;
    n     = (s < S) ? (s + 1) * (N / S) : N;
    fill  = 16'((32'd1 << n) - 32'd1);
    h     = (s < S) ? ((s + 1) * (N / 2)) / S : N / 2;
    half  = 8'((32'd1 << h) - 32'd1);
    halfr = {<<{half}};
    case (mode)
      0:       res = 16'h0000;
      1:       res = fill;
      2:       res = {<<{fill}};
      3:       res = (s % 2 == 0) ? 16'hFFFF : 16'h0000;
      4:       res = (s % 2 == 0) ? 16'h00FF : 16'hFF00;
      5:       res = (s < S) ? 16'(32'h000F << (4 * s)) : 16'h0000;
      6:       res = {half, halfr};
      default: res = 16'hFFFF;
    endcase
    return res;
  endfunction

  function automatic logic [15:0] compose(input logic [15:0] d);
    logic [15:0] lit;
    lit = d;
`ifdef ARROWBOARD_DIM_EN
    if (m_pwm > int'(dim)) lit = 16'h0000;
`endif
    return ((lit | {16{~lt}}) & {16{bi}}) ^ {16{~al}};
  endfunction

  // Cycle model: timing of steps, frames and mode hand-over in plain integers.
  int          m_presc = 0, m_step = 0, m_mode = 0, m_pend = 0;
  bit          m_pflag = 0, m_fs = 0, m_tick;
  logic [15:0] m_lamps = 16'h0000, m_nl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_presc = 0; m_step = 0; m_mode = 0; m_pend = 0;
      m_pflag = 0; m_fs = 0; m_lamps = 16'h0000;
`ifdef ARROWBOARD_DIM_EN
      m_pwm = 0;
`endif
    end else begin
      m_nl = compose(pattern(m_mode, m_step));
      if (m_mode == 0 && m_pflag) begin
        m_mode = m_pend; m_step = 0; m_presc = 0; m_fs = 0; m_pflag = mode_load;
      end else begin
        m_tick = ena && (m_presc == DIV - 1);
        if (ena) m_presc = m_tick ? 0 : m_presc + 1;
        m_fs = m_tick && (m_step == S + 1);
        if (m_tick) m_step = (m_step + 1) % (S + 2);
        if (m_fs && m_pflag) begin
          m_mode = m_pend; m_pflag = mode_load;
        end else if (mode_load) begin
          m_pflag = 1;
        end
      end
      if (mode_load) m_pend = int'(mode_req);
      m_lamps = m_nl;
`ifdef ARROWBOARD_DIM_EN
      m_pwm = (m_pwm + 1) % 16;
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_lamps", 32'(lamps), 32'(m_lamps));
      check("cyc_step", 32'(step), 32'(m_step));
      check("cyc_frame_start", 32'(frame_start), 32'(m_fs));
      check("cyc_mode_pending", 32'(mode_pending), 32'(m_pflag));
    end
  end

  task automatic load(input logic [2:0] m);
    @(negedge clk); mode_req = m; mode_load = 1'b1;
    @(negedge clk); mode_load = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 60);
    if (frame_start !== 1'b1) check("timeout_frame_start", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_step(input logic [2:0] v);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (step !== v && n < 60);
    if (step !== v) check("timeout_step", 32'(step), 32'(v));
  endtask

  task automatic check_frame(input string nm, input logic [15:0] e0, e1, e2, e3, e4, e5);
    logic [15:0] e [6];
    e = '{e0, e1, e2, e3, e4, e5};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check(nm, 32'(lamps), 32'(e[k / 2]));
    end
  endtask

  initial begin
    int cnt;
    check("pin_right_s2", 32'(pattern(1, 2)), 32'h0FFF);
    check("pin_left_s0", 32'(pattern(2, 0)), 32'hF000);
    check("pin_double_s1", 32'(pattern(6, 1)), 32'h0FF0);
    check("pin_chase_s3", 32'(pattern(5, 3)), 32'hF000);
    check("pin_caution_s1", 32'(pattern(4, 1)), 32'hFF00);

    repeat (3) @(negedge clk);
    check("rst_lamps", 32'(lamps), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_mode_pending", 32'(mode_pending), 32'h0);
    rst_n = 1'b1;

    // Right fill from OFF: applies on the following clock, then six 2-clock steps.
    load(3'd1);
    @(negedge clk);
    check_frame("right_seq", 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (frame_start) cnt++;
    end
    check("frame_start_per_24", 32'(cnt), 32'd2);

    load(3'd2);
    wait_fs();
    check_frame("left_seq", 16'hF000, 16'hFF00, 16'hFFF0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    load(3'd6);
    wait_fs();
    check_frame("double_seq", 16'h03C0, 16'h0FF0, 16'h3FFC, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Two loads inside one frame: the later one is what starts on the next frame.
    load(3'd1);
    wait_fs();
    wait_step(3'd2);
    mode_req = 3'd3; mode_load = 1'b1;
    @(negedge clk); mode_load = 1'b0;
    wait_step(3'd3);
    mode_req = 3'd5; mode_load = 1'b1;
    @(negedge clk); mode_load = 1'b0;
    check("pending_after_loads", 32'(mode_pending), 32'd1);
    wait_fs();
    check_frame("chase_last_wins", 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h0000, 16'h0000);

    load(3'd7);
    wait_fs();
    check_frame("steady", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    lt = 1'b0;
    @(negedge clk); check("lamp_test", 32'(lamps), 32'hFFFF);
    bi = 1'b0;
    @(negedge clk); check("blank_beats_lt", 32'(lamps), 32'h0000);
    lt = 1'b1; bi = 1'b1; al = 1'b0;
    @(negedge clk); check("active_low_steady", 32'(lamps), 32'h0000);
    load(3'd0);
    wait_fs();
    @(negedge clk); check("active_low_off", 32'(lamps), 32'hFFFF);
    al = 1'b1;
    @(negedge clk);

    // Freeze timing mid-frame with ena low.
    load(3'd1);
    wait_step(3'd1);
    ena = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("ena_hold_lamps", 32'(lamps), 32'h00FF);
      check("ena_hold_fs", 32'(frame_start), 32'd0);
    end
    ena = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges with a mode still pending.
    load(3'd3);
    check("pending_before_rst", 32'(mode_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_lamps", 32'(lamps), 32'h0000);
    check("async_rst_pending", 32'(mode_pending), 32'd0);
    check("async_rst_step", 32'(step), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_off", 32'(lamps), 32'h0000);

`ifdef ARROWBOARD_DIM_EN
    load(3'd7);
    dim = 4'd3;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (lamps[0]) cnt++;
    end
    check("dim3_duty", 32'(cnt), 32'd4);
    lt = 1'b0;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (lamps[0]) cnt++;
    end
    check("dim_lt_full", 32'(cnt), 32'd16);
    lt = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
